// File: rtl/prealign.sv
// prealign: FP adder operand pre-alignment (unpack, magnitude order, right-shift of the smaller significand).
// Define PREALIGN_BARREL_EN to perform the whole alignment shift in a single SHIFT cycle.
module prealign #(
   parameter int WEXP = 8,
   parameter int WSIG = 23,
   parameter int STEP = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WEXP+WSIG:0] opa,
   input  logic [WEXP+WSIG:0] opb,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WSIG:0]      bigsig,
   output logic [WSIG:0]      alignsig,
   output logic               guard,
   output logic               presticky,
   output logic [WEXP-1:0]    biggerexp,
   output logic               effop,
   output logic               signout,
   output logic               swapped,
   output logic               special
);
   localparam int MAXSH = WSIG + 3;
   localparam int RW    = $clog2(MAXSH + 1);
   localparam int XW    = WSIG + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t            state_r, state_s;
   logic [RW-1:0]     rem_r, rem_s, k_s, clamp_s;
   logic [WEXP-1:0]   ea_s, eb_s, diff_s;
   logic [WSIG:0]     ma_s, mb_s;
   logic              bgt_s, spec_s;
   logic [2*XW-1:0]   wide_s;
   logic [WSIG:0]     bigsig_s, alignsig_s;
   logic              guard_s, presticky_s, effop_s, signout_s, swapped_s, special_s;
   logic [WEXP-1:0]   biggerexp_s;

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);

   // Operand decode: denormals get hidden bit 0 and effective exponent 1.
   always_comb begin
      ea_s   = (opa[WSIG +: WEXP] == {WEXP{1'b0}}) ? {{(WEXP-1){1'b0}}, 1'b1} : opa[WSIG +: WEXP];
      eb_s   = (opb[WSIG +: WEXP] == {WEXP{1'b0}}) ? {{(WEXP-1){1'b0}}, 1'b1} : opb[WSIG +: WEXP];
      ma_s   = {(opa[WSIG +: WEXP] != {WEXP{1'b0}}), opa[WSIG-1:0]};
      mb_s   = {(opb[WSIG +: WEXP] != {WEXP{1'b0}}), opb[WSIG-1:0]};
      bgt_s  = ({eb_s, mb_s} > {ea_s, ma_s});
      spec_s = (&opa[WSIG +: WEXP]) | (&opb[WSIG +: WEXP]);
      diff_s = bgt_s ? (eb_s - ea_s) : (ea_s - eb_s);
      if (diff_s > WEXP'(MAXSH)) begin
         clamp_s = RW'(MAXSH);
      end else begin
         clamp_s = diff_s[RW-1:0];
      end
   end

   // Per-cycle shift distance and the {alignsig, guard} shifter with shifted-out bits below.
   always_comb begin
`ifdef PREALIGN_BARREL_EN
      k_s = rem_r;
`else
      if (rem_r > RW'(STEP)) begin
         k_s = RW'(STEP);
      end else begin
         k_s = rem_r;
      end
`endif
      wide_s = {alignsig, guard, {XW{1'b0}}} >> k_s;
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_s     = state_r;
      rem_s       = rem_r;
      bigsig_s    = bigsig;
      alignsig_s  = alignsig;
      guard_s     = guard;
      presticky_s = presticky;
      biggerexp_s = biggerexp;
      effop_s     = effop;
      signout_s   = signout;
      swapped_s   = swapped;
      special_s   = special;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               bigsig_s    = bgt_s ? mb_s : ma_s;
               alignsig_s  = bgt_s ? ma_s : mb_s;
               guard_s     = 1'b0;
               presticky_s = 1'b0;
               biggerexp_s = bgt_s ? eb_s : ea_s;
               effop_s     = opa[WEXP+WSIG] ^ opb[WEXP+WSIG] ^ sub;
               signout_s   = bgt_s ? (opb[WEXP+WSIG] ^ sub) : opa[WEXP+WSIG];
               swapped_s   = bgt_s;
               special_s   = spec_s;
               rem_s       = clamp_s;
               if (spec_s || (clamp_s == {RW{1'b0}})) begin
                  state_s = DONE;
               end else begin
                  state_s = SHIFT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            alignsig_s  = wide_s[2*XW-1 -: (WSIG+1)];
            guard_s     = wide_s[XW];
            presticky_s = presticky | (|wide_s[XW-1:0]);
            rem_s       = rem_r - k_s;
            if (rem_r == k_s) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         rem_r     <= {RW{1'b0}};
         bigsig    <= {(WSIG+1){1'b0}};
         alignsig  <= {(WSIG+1){1'b0}};
         guard     <= 1'b0;
         presticky <= 1'b0;
         biggerexp <= {WEXP{1'b0}};
         effop     <= 1'b0;
         signout   <= 1'b0;
         swapped   <= 1'b0;
         special   <= 1'b0;
      end else begin
         state_r   <= state_s;
         rem_r     <= rem_s;
         bigsig    <= bigsig_s;
         alignsig  <= alignsig_s;
         guard     <= guard_s;
         presticky <= presticky_s;
         biggerexp <= biggerexp_s;
         effop     <= effop_s;
         signout   <= signout_s;
         swapped   <= swapped_s;
         special   <= special_s;
      end
   end
endmodule
